spi_initiator: RTL and testbench

SPI_INITIATOR -- requirements
Module: spi_initiator

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clkgen.sv | 49 ++++
 rtl/spi_initiator.sv | 209 ++++++++++++++++++++
 tb/tb_spi_initiator.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator.
//   spi_byte_t  : one SPI data byte
//   spi_state_t : frame sequencer states
//   SPI_BITS    : bits per transferred byte
package spi_pkg;

    localparam int SPI_BITS = 8;

    typedef logic [SPI_BITS-1:0] spi_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period divider for the SPI initiator.
// Issues a one-cycle strobe every DIV clk cycles while run is high.
// Strobes alternate between fall_en and rise_en.
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   run     : count enable; when low, the divider is held cleared
//   rise_en : strobe marking the end of a low half-period
//   fall_en : strobe marking the end of a high half-period
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic rise_en,
    output logic fall_en
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          rise_next;
    logic          tick;

    assign tick    = run && (cnt == LAST);
    assign rise_en = tick && rise_next;
    assign fall_en = tick && !rise_next;

    // The first strobe after a clear is a "fall". The top uses it to close
    // the setup period, which is the leading low half of the first bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            rise_next <= 1'b0;
        end else if (!run) begin
            cnt       <= '0;
            rise_next <= 1'b0;
        end else if (tick) begin
            cnt       <= '0;
            rise_next <= !rise_next;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator with a single-entry transmit holding register.
// Sends bytes MSB first and frames them with an active-high cs.
// Optional full-duplex receive is enabled with the macro SPI_INITIATOR_RX_EN.
//   clk      : system clock
//   reset    : asynchronous, active-low reset
//   tx_data  : byte to send
//   tx_valid : tx_data and tx_last are valid
//   tx_last  : this byte ends the frame
//   tx_ready : holding register is empty
//   sck      : SPI clock (idles low)
//   sdo      : serial data out
//   cs       : frame select, active-high
//   busy     : sequencer not idle
//   sdi      : serial data in            (SPI_INITIATOR_RX_EN only)
//   rx_data  : last received byte        (SPI_INITIATOR_RX_EN only)
//   rx_valid : one-cycle pulse per byte  (SPI_INITIATOR_RX_EN only)
module spi_initiator
    import spi_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       sck,
    output logic       sdo,
    output logic       cs,
    output logic       busy
`ifdef SPI_INITIATOR_RX_EN
    ,
    input  logic       sdi,
    output logic [7:0] rx_data,
    output logic       rx_valid
`endif
);

    spi_state_t state;
    spi_state_t state_next;

    spi_byte_t  hold_data;
    logic       hold_last;
    logic       hold_full;
    spi_byte_t  shift_reg;
    logic       shift_last;
    logic [2:0] bit_cnt;
    logic       starved;

    logic       rise_en;
    logic       fall_en;
    logic       run;
    logic       accept;
    logic       shift_active;
    logic       shift_fall;
    logic       byte_done;
    logic       move;

    assign tx_ready     = !hold_full;
    assign accept       = tx_valid && !hold_full;
    assign shift_active = (state == SHIFT) && !starved;
    assign shift_fall   = shift_active && fall_en;
    assign byte_done    = shift_fall && (bit_cnt == 3'(SPI_BITS - 1));

    // The holding register empties either at the end of setup or at the
    // byte boundary of a frame that continues. The new MSB then appears on
    // that same falling edge.
    assign move = ((state == SETUP) && fall_en)
                || (byte_done && !shift_last && hold_full);

    // The divider is idle between frames and while waiting for a byte in
    // the middle of a frame. Each restart then begins with a full setup.
    assign run = (state != IDLE) && !((state == SHIFT) && starved);

    spi_clkgen #(
        .DIV(DIV)
    ) u_clkgen (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .rise_en(rise_en),
        .fall_en(fall_en)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // During SETUP, sdo is taken from the holding register. The MSB is
    // therefore visible the cycle after the accept, before the byte moves
    // into the shifter.
    always_comb begin
        state_next = state;
        cs         = 1'b0;
        busy       = 1'b1;
        sdo        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (hold_full || accept) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                cs  = 1'b1;
                sdo = hold_data[SPI_BITS-1];
                if (fall_en) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                cs  = 1'b1;
                sdo = shift_reg[SPI_BITS-1];
                if (starved) begin
                    if (hold_full || accept) begin
                        state_next = SETUP;
                    end
                end else if (byte_done && shift_last) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (rise_en || fall_en) begin
                    state_next = (hold_full || accept) ? SETUP : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding register, shifter, bit counter, starvation flag and sck.
    // An accept and a move never happen together, because an accept needs
    // an empty holding register and a move needs a full one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            shift_reg  <= '0;
            shift_last <= 1'b0;
            bit_cnt    <= '0;
            starved    <= 1'b0;
            sck        <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
            end else if (move) begin
                hold_full <= 1'b0;
            end

            if (move) begin
                shift_reg  <= hold_data;
                shift_last <= hold_last;
                bit_cnt    <= '0;
            end else if (shift_fall) begin
                shift_reg <= {shift_reg[SPI_BITS-2:0], 1'b0};
                bit_cnt   <= bit_cnt + 3'd1;
            end

            if (byte_done && !shift_last && !hold_full) begin
                starved <= 1'b1;
            end else if (starved && (hold_full || accept)) begin
                starved <= 1'b0;
            end

            if (shift_active) begin
                if (rise_en) begin
                    sck <= 1'b1;
                end else if (fall_en) begin
                    sck <= 1'b0;
                end
            end else begin
                sck <= 1'b0;
            end
        end
    end

`ifdef SPI_INITIATOR_RX_EN
    spi_byte_t rx_shift;

    // Receive shifter: captures sdi on each sck rise and publishes the
    // completed byte on the eighth fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= byte_done;
            if (shift_active && rise_en) begin
                rx_shift <= {rx_shift[SPI_BITS-2:0], sdi};
            end
            if (byte_done) begin
                rx_data <= rx_shift;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_initiator.sv
// Self-checking bench for spi_initiator (DIV = 2).
// A byte-level scoreboard predicts the bit on sdo at every sck rise.
// Frame timing is measured from cs, sck and busy, and directed cases pin
// the measurements with hand-computed numbers.
module tb_spi_initiator;

    localparam int DIV = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } tx_item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       sck;
    logic       sdo;
    logic       cs;
    logic       busy;
`ifdef SPI_INITIATOR_RX_EN
    logic       sdi;
    logic [7:0] rx_data;
    logic       rx_valid;
    assign sdi = sdo;
`endif

    int checks = 0;
    int errors = 0;

    tx_item_t   exp_q[$];
    tx_item_t   item;
    logic [7:0] cur_byte = '0;
    logic       cur_last = 1'b0;
    int         bit_idx = 8;
    logic       prev_sck = 1'b0;
    logic       prev_cs = 1'b0;
    logic       prev_sdo = 1'b0;
    int         high_len = 0;
    int         low_len = 0;
    int         max_low = 0;
    int         cs_len = 0;
    int         gap_len = 0;
    int         frame_rises = 0;
    logic [7:0] seen_bits = '0;
    int         frames_done = 0;
    int         last_cs_len = 0;
    int         last_gap = 0;
    int         last_frame_rises = 0;
    logic [7:0] last_frame_bits = '0;
    logic       tracking = 1'b0;
    int         busy_cnt = 0;
    int         last_busy_delay = -1;
    int         start;

    spi_initiator #(
        .DIV(DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .sck     (sck),
        .sdo     (sdo),
        .cs      (cs),
        .busy    (busy)
`ifdef SPI_INITIATOR_RX_EN
        ,
        .sdi     (sdi),
        .rx_data (rx_data),
        .rx_valid(rx_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired, got no event, expected one at %0t", name, $time);
    endtask

    // Present one byte and hold it until the DUT takes it. The byte is then
    // queued as the expected content of the next sck rises.
    task automatic applyStimulus(input logic [7:0] data, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        tx_data  = data;
        tx_last  = last;
        tx_valid = 1'b1;
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            timeoutFail("accept_timeout");
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back({data, last});
        #1;
        tx_valid = 1'b0;
        checkOutput("tx_ready_after_accept", tx_ready, 1'b0);
    endtask

    task automatic waitFrames(input int target);
        int n;
        n = 0;
        while (frames_done < target && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (frames_done < target) timeoutFail("frame_timeout");
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (busy) timeoutFail("idle_timeout");
    endtask

    // Compare process: checks the scoreboard bit at every sck rise, checks
    // the framing invariants every cycle, and measures frame timing.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            bit_idx     = 8;
            cur_last    = 1'b0;
            prev_sck    = 1'b0;
            prev_cs     = 1'b0;
            prev_sdo    = 1'b0;
            frame_rises = 0;
            tracking    = 1'b0;
        end else begin
            if (tracking) begin
                if (busy) busy_cnt++;
                else begin
                    last_busy_delay = busy_cnt;
                    tracking = 1'b0;
                end
            end

            checkOutput("sck_outside_cs", sck & ~cs, 1'b0);
            checkOutput("busy_covers_cs", cs & ~busy, 1'b0);

            if (cs && !prev_cs) begin
                cs_len      = 1;
                last_gap    = gap_len;
                frame_rises = 0;
                max_low     = 0;
            end else if (cs) begin
                cs_len++;
            end

            if (sck && !prev_sck) begin
                if (bit_idx >= 8) begin
                    if (exp_q.size() == 0) begin
                        timeoutFail("sck_rise_without_data");
                    end else begin
                        item     = exp_q.pop_front();
                        cur_byte = item.data;
                        cur_last = item.last;
                        bit_idx  = 0;
                    end
                end
                if (bit_idx < 8) begin
                    checkOutput("sdo_bit", sdo, cur_byte[7-bit_idx]);
                    bit_idx++;
                end
                if (frame_rises > 0 && low_len > max_low) max_low = low_len;
                high_len = 1;
                frame_rises++;
                seen_bits = {seen_bits[6:0], sdo};
            end else if (sck) begin
                high_len++;
            end

            if (!sck && prev_sck) begin
                checkValue("sck_high_len", high_len, DIV);
                low_len = 1;
            end else if (!sck) begin
                low_len++;
            end

            if (sck && prev_sck) checkOutput("sdo_stable_while_sck_high", sdo, prev_sdo);

`ifdef SPI_INITIATOR_RX_EN
            if (rx_valid) checkValue("rx_data", int'(rx_data), int'(cur_byte));
`endif

            if (!cs && prev_cs) begin
                checkOutput("frame_end_after_8_bits", bit_idx == 8, 1'b1);
                checkOutput("frame_end_on_last", cur_last, 1'b1);
                last_cs_len      = cs_len;
                last_frame_rises = frame_rises;
                last_frame_bits  = seen_bits;
                gap_len          = 1;
                frames_done++;
                tracking         = busy;
                busy_cnt         = busy ? 1 : 0;
                if (!busy) last_busy_delay = 0;
            end else if (!cs) begin
                gap_len++;
            end

            prev_sck = sck;
            prev_cs  = cs;
            prev_sdo = sdo;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset    = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_sck", sck, 1'b0);
        checkOutput("reset_sdo", sdo, 1'b0);
        checkOutput("reset_cs", cs, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_tx_ready", tx_ready, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: setup 2 + 16 half-periods of 2 = 34 cycles of cs.
        $display("[TB] single byte 0xA5");
        start = frames_done;
        applyStimulus(8'hA5, 1'b1);
        checkOutput("cs_after_accept", cs, 1'b1);
        checkOutput("sdo_msb_in_setup", sdo, 1'b1);
        waitFrames(start + 1);
        checkValue("a5_bits", int'(last_frame_bits), 8'hA5);
        checkValue("a5_cs_len", last_cs_len, 34);
        checkValue("a5_rises", last_frame_rises, 8);
        checkValue("a5_busy_delay", last_busy_delay, 2);

        // Two bytes streamed: 2 + 32*2 = 66 cycles, sck never idles.
        $display("[TB] streamed 0x3C, 0xFF");
        start = frames_done;
        applyStimulus(8'h3C, 1'b0);
        applyStimulus(8'hFF, 1'b1);
        waitFrames(start + 1);
        checkValue("stream_bits", int'(last_frame_bits), 8'hFF);
        checkValue("stream_cs_len", last_cs_len, 66);
        checkValue("stream_rises", last_frame_rises, 16);
        checkValue("stream_max_sck_low", max_low, 2);

        // Back-to-back frames: cs low only for the 2-cycle gap.
        $display("[TB] back-to-back frames 0x01, 0x80");
        start = frames_done;
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h80, 1'b1);
        waitFrames(start + 2);
        checkValue("b2b_gap", last_gap, 2);
        checkValue("b2b_bits", int'(last_frame_bits), 8'h80);
        checkValue("b2b_rises", last_frame_rises, 8);
        checkValue("b2b_cs_len", last_cs_len, 34);

        // Starvation: the frame stays open with sck low until 0xAA arrives.
        $display("[TB] starvation 0x55 then 0xAA");
        start = frames_done;
        applyStimulus(8'h55, 1'b0);
        repeat (80) @(negedge clk);
        #1;
        checkOutput("starve_cs", cs, 1'b1);
        checkOutput("starve_sck", sck, 1'b0);
        checkOutput("starve_busy", busy, 1'b1);
        checkOutput("starve_tx_ready", tx_ready, 1'b1);
        applyStimulus(8'hAA, 1'b1);
        waitFrames(start + 1);
        checkValue("starve_bits", int'(last_frame_bits), 8'hAA);
        checkValue("starve_rises", last_frame_rises, 16);
        checkOutput("starve_cs_long", last_cs_len > 114, 1'b1);

        // Reset during the 4th bit of 0xF0, then 0x0F sent cleanly.
        $display("[TB] reset mid-frame");
        applyStimulus(8'hF0, 1'b1);
        @(negedge clk);
        #1;
        n = 0;
        while (frame_rises != 4 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (frame_rises != 4) timeoutFail("fourth_rise_timeout");
        checkOutput("pre_reset_sck", sck, 1'b1);
        reset = 1'b0;
        #1;
        checkOutput("abort_cs", cs, 1'b0);
        checkOutput("abort_sck", sck, 1'b0);
        checkOutput("abort_sdo", sdo, 1'b0);
        checkOutput("abort_tx_ready", tx_ready, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("after_reset_busy", busy, 1'b0);
        start = frames_done;
        applyStimulus(8'h0F, 1'b1);
        waitFrames(start + 1);
        checkValue("resume_bits", int'(last_frame_bits), 8'h0F);
        checkValue("resume_rises", last_frame_rises, 8);
        checkValue("resume_cs_len", last_cs_len, 34);

        checkValue("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
